// File: rtl/dram_bridge_pkg.sv
// Shared types and constants for the core-to-DRAM AXI4-Lite bridge.
// Record addressing lives here so the bench and any future user agree on the layout.
package usertype;

    localparam int DRAM_ADDR_W = 17;
    localparam int DRAM_DATA_W = 64;
    localparam int USER_ID_W   = 8;

    localparam logic [DRAM_ADDR_W-1:0] DEF_BASE_ADDR = 17'h10000;
    localparam int                     DEF_REC_BYTES = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } bridge_state_t;

    // 255 * 8 + 17'h10000 = 17'h107F8, so the sum never leaves 17 bits.
    function automatic logic [DRAM_ADDR_W-1:0] rec_addr(
        input logic [DRAM_ADDR_W-1:0] base,
        input int                     stride,
        input logic [USER_ID_W-1:0]   id
    );
        return base + DRAM_ADDR_W'(id) * DRAM_ADDR_W'(stride);
    endfunction

endpackage

// File: rtl/dram_bridge.sv
// Single-outstanding bridge: one core read/write becomes one AXI4-Lite transaction.
// Outputs decode only from registered state, so no input reaches an output combinationally.
module dram_bridge
    import usertype::*;
#(
    parameter logic [DRAM_ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int                     REC_BYTES = DEF_REC_BYTES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   C_in_valid,
    input  logic [USER_ID_W-1:0]   C_addr,
    input  logic                   C_r_wb,
    input  logic [DRAM_DATA_W-1:0] C_data_w,
    output logic                   C_out_valid,
    output logic [DRAM_DATA_W-1:0] C_data_r,
    output logic                   AR_VALID,
    output logic [DRAM_ADDR_W-1:0] AR_ADDR,
    input  logic                   AR_READY,
    input  logic                   R_VALID,
    input  logic [DRAM_DATA_W-1:0] R_DATA,
    input  logic [1:0]             R_RESP,
    output logic                   R_READY,
    output logic                   AW_VALID,
    output logic [DRAM_ADDR_W-1:0] AW_ADDR,
    input  logic                   AW_READY,
    output logic                   W_VALID,
    output logic [DRAM_DATA_W-1:0] W_DATA,
    input  logic                   W_READY,
    input  logic                   B_VALID,
    input  logic [1:0]             B_RESP,
    output logic                   B_READY
);

    bridge_state_t          state_q, state_d;
    logic [DRAM_ADDR_W-1:0] addr_q,  addr_d;
    logic [DRAM_DATA_W-1:0] wdata_q, wdata_d;
    logic [DRAM_DATA_W-1:0] rdata_q, rdata_d;
    logic                   rwb_q,   rwb_d;

    // DRAM always answers OKAY; responses are deliberately dropped.
    logic unused_resp;
    assign unused_resp = ^{R_RESP, B_RESP};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rwb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rwb_q   <= rwb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rwb_d   = rwb_q;
        unique case (state_q)
            S_IDLE: begin
                if (C_in_valid) begin
                    addr_d  = rec_addr(BASE_ADDR, REC_BYTES, C_addr);
                    wdata_d = C_data_w;
                    rwb_d   = C_r_wb;
                    rdata_d = '0;
                    state_d = C_r_wb ? S_AR : S_AW;
                end
            end
            S_AR:   if (AR_READY) state_d = S_R;
            S_R: begin
                if (R_VALID) begin
                    rdata_d = R_DATA;
                    state_d = S_DONE;
                end
            end
            S_AW:   if (AW_READY) state_d = S_W;
            S_W:    if (W_READY)  state_d = S_B;
            S_B:    if (B_VALID)  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        AR_VALID    = (state_q == S_AR);
        R_READY     = (state_q == S_R);
        AW_VALID    = (state_q == S_AW);
        W_VALID     = (state_q == S_W);
        B_READY     = (state_q == S_B);
        C_out_valid = (state_q == S_DONE);
        AR_ADDR     = addr_q;
        AW_ADDR     = addr_q;
        W_DATA      = wdata_q;
        C_data_r    = (C_out_valid && rwb_q) ? rdata_q : '0;
    end

endmodule

// File: tb/tb_dram_bridge.sv
// Directed and randomized checks of dram_bridge against a small AXI4-Lite DRAM slave
// with programmable per-channel stall counts and a per-id scoreboard.
module tb_dram_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        C_in_valid;
    logic [7:0]  C_addr;
    logic        C_r_wb;
    logic [63:0] C_data_w;
    logic        C_out_valid;
    logic [63:0] C_data_r;
    logic        AR_VALID, AR_READY, R_VALID, R_READY;
    logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
    logic [16:0] AR_ADDR, AW_ADDR;
    logic [63:0] R_DATA, W_DATA;
    logic [1:0]  R_RESP, B_RESP;

    int checks = 0;
    int errors = 0;

    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    int ar_hs = 0, aw_hs = 0, ov_cnt = 0;
    logic [7:0]  rd_idx, wr_idx;
    logic [63:0] mem [256];
    logic [63:0] sb  [256];
    logic        init_done = 1'b0;

    always #5 clk = ~clk;

    dram_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .C_in_valid(C_in_valid), .C_addr(C_addr), .C_r_wb(C_r_wb), .C_data_w(C_data_w),
        .C_out_valid(C_out_valid), .C_data_r(C_data_r),
        .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
        .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
    );

    function automatic logic [63:0] pat(input int i);
        return 64'h0123_4567_89AB_CDEF ^ (64'(i) << 32);
    endfunction

    function automatic logic [7:0] idx_of(input logic [16:0] a);
        logic [16:0] o;
        o = a - 17'h10000;
        return o[10:3];
    endfunction

    // DRAM slave model: each READY/VALID waits <delay> cycles once the other side is up.
    assign AR_READY = AR_VALID && (ar_cnt >= ar_delay);
    assign AW_READY = AW_VALID && (aw_cnt >= aw_delay);
    assign W_READY  = W_VALID  && (w_cnt  >= w_delay);
    assign R_VALID  = R_READY  && (r_cnt  >= r_delay);
    assign B_VALID  = B_READY  && (b_cnt  >= b_delay);
    assign R_DATA   = R_VALID ? mem[rd_idx] : 64'h0;
    assign R_RESP   = 2'b00;
    assign B_RESP   = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            rd_idx <= 8'd0; wr_idx <= 8'd0;
            if (!init_done) begin
                for (int i = 0; i < 256; i++) mem[i] <= pat(i);
                init_done <= 1'b1;
            end
        end else begin
            ar_cnt <= (AR_VALID && !AR_READY) ? ar_cnt + 1 : 0;
            aw_cnt <= (AW_VALID && !AW_READY) ? aw_cnt + 1 : 0;
            w_cnt  <= (W_VALID  && !W_READY)  ? w_cnt + 1  : 0;
            r_cnt  <= (R_READY  && !R_VALID)  ? r_cnt + 1  : 0;
            b_cnt  <= (B_READY  && !B_VALID)  ? b_cnt + 1  : 0;
            if (AR_VALID && AR_READY) begin
                rd_idx <= idx_of(AR_ADDR);
                ar_hs  <= ar_hs + 1;
            end
            if (AW_VALID && AW_READY) begin
                wr_idx <= idx_of(AW_ADDR);
                aw_hs  <= aw_hs + 1;
            end
            if (W_VALID && W_READY) mem[wr_idx] <= W_DATA;
            if (C_out_valid) ov_cnt <= ov_cnt + 1;
        end
    end

    task automatic drive_req(input logic [7:0] id, input logic rwb, input logic [63:0] d);
        C_in_valid = 1'b1; C_addr = id; C_r_wb = rwb; C_data_w = d;
        @(negedge clk);
        C_in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        int n = 0;
        while (!C_out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = C_out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; C_in_valid = 1'b0; C_addr = '0; C_r_wb = 1'b0; C_data_w = '0;
        for (int i = 0; i < 256; i++) sb[i] = pat(i);
        repeat (3) @(negedge clk);
        checks++;
        if ({AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
             C_out_valid, C_data_r} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: AR_V=%b AR_A=%h AW_V=%b W_V=%b OV=%b got nonzero, want 0",
                     AR_VALID, AR_ADDR, AW_VALID, W_VALID, C_out_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_basic();
        drive_req(8'd0, 1'b1, 64'h0);
        checks++;
        if (AR_VALID !== 1'b1 || AR_ADDR !== 17'h10000 || C_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_ar_t1: AR_VALID=%b AR_ADDR=%h OV=%b want 1 10000 0", AR_VALID, AR_ADDR, C_out_valid);
        end
        @(negedge clk);
        checks++;
        if (R_READY !== 1'b1 || AR_VALID !== 1'b0 || C_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_r_t2: R_READY=%b AR_VALID=%b OV=%b want 1 0 0", R_READY, AR_VALID, C_out_valid);
        end
        @(negedge clk);
        checks++;
        if (C_out_valid !== 1'b1 || C_data_r !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL rd_done_t3: OV=%b data=%h want 1 0123456789abcdef", C_out_valid, C_data_r);
        end
        @(negedge clk);
        checks++;
        if (C_out_valid !== 1'b0 || C_data_r !== 64'h0) begin
            errors++;
            $display("FAIL rd_done_pulse: OV=%b data=%h want 0 0", C_out_valid, C_data_r);
        end
    endtask

    task automatic test_write_basic();
        logic [63:0] d = 64'hDEAD_BEEF_0000_0001;
        drive_req(8'd255, 1'b0, d);
        checks++;
        if (AW_VALID !== 1'b1 || AW_ADDR !== 17'h107F8 || AR_VALID !== 1'b0) begin
            errors++;
            $display("FAIL wr_aw_t1: AW_VALID=%b AW_ADDR=%h AR_VALID=%b want 1 107f8 0", AW_VALID, AW_ADDR, AR_VALID);
        end
        @(negedge clk);
        checks++;
        if (W_VALID !== 1'b1 || W_DATA !== d || AW_VALID !== 1'b0) begin
            errors++;
            $display("FAIL wr_w_t2: W_VALID=%b W_DATA=%h AW_VALID=%b want 1 %h 0", W_VALID, W_DATA, AW_VALID, d);
        end
        @(negedge clk);
        checks++;
        if (B_READY !== 1'b1 || W_VALID !== 1'b0 || C_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_b_t3: B_READY=%b W_VALID=%b OV=%b want 1 0 0", B_READY, W_VALID, C_out_valid);
        end
        @(negedge clk);
        checks++;
        if (C_out_valid !== 1'b1 || C_data_r !== 64'h0 || mem[255] !== d) begin
            errors++;
            $display("FAIL wr_done_t4: OV=%b data=%h mem=%h want 1 0 %h", C_out_valid, C_data_r, mem[255], d);
        end
        sb[255] = d;
        @(negedge clk);
    endtask

    task automatic test_ar_delay();
        int   hs0 = ar_hs;
        int   bad = 0;
        logic ok;
        ar_delay = 15;
        drive_req(8'd7, 1'b1, 64'h0);
        for (int i = 0; i < 15; i++) begin
            if (AR_VALID !== 1'b1 || AR_ADDR !== 17'h10038 || AR_READY !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ar_stall_stable: %0d unstable cycles, want 0", bad);
        end
        checks++;
        if (AR_VALID !== 1'b1 || AR_READY !== 1'b1) begin
            errors++;
            $display("FAIL ar_stall_hs: AR_VALID=%b AR_READY=%b want 1 1", AR_VALID, AR_READY);
        end
        wait_done(20, ok);
        checks++;
        if (!ok || C_data_r !== sb[7]) begin
            errors++;
            $display("FAIL ar_stall_done: ok=%b data=%h want 1 %h", ok, C_data_r, sb[7]);
        end
        @(negedge clk);
        checks++;
        if (ar_hs - hs0 != 1) begin
            errors++;
            $display("FAIL ar_stall_count: %0d handshakes, want 1", ar_hs - hs0);
        end
        ar_delay = 0;
    endtask

    task automatic test_ignore_in_r();
        int   hs0 = ar_hs, aw0 = aw_hs, ov0 = ov_cnt;
        logic ok;
        r_delay = 4;
        drive_req(8'd2, 1'b1, 64'h0);
        @(negedge clk);
        checks++;
        if (R_READY !== 1'b1) begin
            errors++;
            $display("FAIL ign_in_r: R_READY=%b want 1", R_READY);
        end
        drive_req(8'd9, 1'b0, 64'h5555);
        wait_done(20, ok);
        checks++;
        if (!ok || C_data_r !== sb[2]) begin
            errors++;
            $display("FAIL ign_done: ok=%b data=%h want 1 %h", ok, C_data_r, sb[2]);
        end
        @(negedge clk);
        checks++;
        if (C_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ign_pulse: OV=%b want 0", C_out_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ar_hs - hs0 != 1 || aw_hs != aw0 || ov_cnt - ov0 != 1) begin
            errors++;
            $display("FAIL ign_counts: ar=%0d aw=%0d ov=%0d want 1 0 1", ar_hs - hs0, aw_hs - aw0, ov_cnt - ov0);
        end
        r_delay = 0;
    endtask

    task automatic test_reset_mid_w();
        int   n = 0;
        logic ok;
        w_delay = 10;
        drive_req(8'd5, 1'b0, 64'hCAFE_F00D_1234_5678);
        while (!W_VALID && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (W_VALID !== 1'b1) begin
            errors++;
            $display("FAIL rst_reach_w: W_VALID=%b want 1", W_VALID);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
             C_out_valid, C_data_r} !== '0) begin
            errors++;
            $display("FAIL rst_async: W_VALID=%b W_DATA=%h AW_ADDR=%h got nonzero, want 0", W_VALID, W_DATA, AW_ADDR);
        end
        @(negedge clk);
        rst_n = 1'b1;
        w_delay = 0;
        @(negedge clk);
        drive_req(8'd3, 1'b1, 64'h0);
        checks++;
        if (AR_VALID !== 1'b1 || AR_ADDR !== 17'h10018) begin
            errors++;
            $display("FAIL rst_fresh_ar: AR_VALID=%b AR_ADDR=%h want 1 10018", AR_VALID, AR_ADDR);
        end
        wait_done(20, ok);
        checks++;
        if (!ok || C_data_r !== sb[3] || mem[5] !== sb[5]) begin
            errors++;
            $display("FAIL rst_fresh_done: ok=%b data=%h mem5=%h want 1 %h %h", ok, C_data_r, mem[5], sb[3], sb[5]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic        ok, rwb;
        logic [7:0]  id;
        logic [63:0] d;
        for (int n = 0; n < 1000; n++) begin
            ar_delay = $urandom_range(0, 2); r_delay = $urandom_range(0, 2);
            aw_delay = $urandom_range(0, 2); w_delay = $urandom_range(0, 2);
            b_delay  = $urandom_range(0, 2);
            id  = 8'($urandom_range(0, 15));
            rwb = 1'($urandom_range(0, 1));
            d   = {$urandom, $urandom};
            drive_req(id, rwb, d);
            wait_done(40, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL b2b_timeout: op %0d id %0d never completed", n, id);
                break;
            end
            if (rwb) begin
                if (C_data_r !== sb[id]) begin
                    errors++;
                    $display("FAIL b2b_read: op %0d id %0d got %h want %h", n, id, C_data_r, sb[id]);
                end
            end else begin
                if (C_data_r !== 64'h0) begin
                    errors++;
                    $display("FAIL b2b_write: op %0d id %0d got %h want 0", n, id, C_data_r);
                end
                sb[id] = d;
            end
            @(negedge clk);
            checks++;
            if (C_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_pulse: op %0d OV=%b want 0", n, C_out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_basic();
        test_ar_delay();
        test_ignore_in_r();
        test_reset_mid_w();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
